// File: rtl/request_unit.sv
// Request sequencer: instruction fetch, one data access, halt.
// Optional data-access watchdog enabled by REQ_UNIT_TIMEOUT_EN.
module request_unit (
  input  logic CLK,
  input  logic RST,
  input  logic MemRead,
  input  logic MemWrite,
  input  logic mem_halt,
  input  logic ihit,
  input  logic dhit,
  output logic iREN,
  output logic dREN,
  output logic dWEN,
  output logic pc_en,
  output logic halt,
  output logic dto_err
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   rd_q, rd_d;
  logic   wr_q, wr_d;
  logic   halt_q, halt_d;

`ifdef REQ_UNIT_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       dto_q, dto_d;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      halt_q  <= 1'b0;
`ifdef REQ_UNIT_TIMEOUT_EN
      cnt_q   <= 8'd0;
      dto_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      halt_q  <= halt_d;
`ifdef REQ_UNIT_TIMEOUT_EN
      cnt_q   <= cnt_d;
      dto_q   <= dto_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    halt_d  = halt_q;
`ifdef REQ_UNIT_TIMEOUT_EN
    cnt_d   = cnt_q;
    dto_d   = dto_q;
`endif
    iREN    = 1'b0;
    dREN    = 1'b0;
    dWEN    = 1'b0;
    pc_en   = 1'b0;
    unique case (state_q)
      FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          if (mem_halt) begin
            state_d = HALTED;
            halt_d  = 1'b1;
          end else if (MemRead | MemWrite) begin
            // a load+store encoding degrades to a store
            rd_d    = MemRead & ~MemWrite;
            wr_d    = MemWrite;
            state_d = DATA;
`ifdef REQ_UNIT_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
          end else begin
            pc_en = 1'b1;
          end
        end
      end
      DATA: begin
        dREN = rd_q;
        dWEN = wr_q;
        if (dhit) begin
          pc_en   = 1'b1;
          state_d = FETCH;
        end
`ifdef REQ_UNIT_TIMEOUT_EN
        else if (cnt_q == 8'hff) begin
          state_d = HALTED;
          halt_d  = 1'b1;
          dto_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      HALTED: begin
      end
      default: state_d = FETCH;
    endcase
    if (RST) pc_en = 1'b0;
  end

  assign halt = halt_q;

`ifdef REQ_UNIT_TIMEOUT_EN
  assign dto_err = dto_q;
`else
  assign dto_err = 1'b0;
`endif

endmodule

// File: tb/tb_request_unit.sv
// Directed vector bench for request_unit.
// Covers both builds of REQ_UNIT_TIMEOUT_EN.
module tb_request_unit;

  logic CLK = 1'b0;
  logic RST, MemRead, MemWrite, mem_halt, ihit, dhit;
  logic iREN, dREN, dWEN, pc_en, halt, dto_err;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  request_unit dut (
    .CLK(CLK), .RST(RST),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_halt(mem_halt), .ihit(ihit), .dhit(dhit),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .pc_en(pc_en), .halt(halt), .dto_err(dto_err)
  );

  // in = {rst, mr, mw, mh, ih, dh}; out = {i, dr, dw, pe, h, e}
  typedef struct packed {
    logic [5:0] in;
    logic [5:0] out;
  } vec_t;

  vec_t tbl [29];

  task automatic drive(input logic [5:0] v);
    @(negedge CLK);
    {RST, MemRead, MemWrite, mem_halt, ihit, dhit} = v;
    #1;
  endtask

  task automatic chk(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {iREN, dREN, dWEN, pc_en, halt, dto_err};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b (iREN dREN dWEN pc_en halt dto)",
               name, got, exp);
    end
  endtask

  initial begin
    tbl[0]  = '{6'b100000, 6'b100000};
    tbl[1]  = '{6'b000000, 6'b100000};
    tbl[2]  = '{6'b000010, 6'b100100};
    tbl[3]  = '{6'b000010, 6'b100100};
    tbl[4]  = '{6'b000001, 6'b100000};
    tbl[5]  = '{6'b010010, 6'b100000};
    tbl[6]  = '{6'b000000, 6'b010000};
    tbl[7]  = '{6'b000010, 6'b010000};
    tbl[8]  = '{6'b000001, 6'b010100};
    tbl[9]  = '{6'b000000, 6'b100000};
    tbl[10] = '{6'b011010, 6'b100000};
    tbl[11] = '{6'b000000, 6'b001000};
    tbl[12] = '{6'b000001, 6'b001100};
    tbl[13] = '{6'b000000, 6'b100000};
    tbl[14] = '{6'b010010, 6'b100000};
    tbl[15] = '{6'b000000, 6'b010000};
    tbl[16] = '{6'b100001, 6'b010000};
    tbl[17] = '{6'b000000, 6'b100000};
    tbl[18] = '{6'b001110, 6'b100000};
    tbl[19] = '{6'b000000, 6'b000010};
    tbl[20] = '{6'b000011, 6'b000010};
    tbl[21] = '{6'b010010, 6'b000010};
    tbl[22] = '{6'b100000, 6'b000010};
    tbl[23] = '{6'b000000, 6'b100000};
    tbl[24] = '{6'b000010, 6'b100100};
    tbl[25] = '{6'b001010, 6'b100000};
    tbl[26] = '{6'b000000, 6'b001000};
    tbl[27] = '{6'b000001, 6'b001100};
    tbl[28] = '{6'b000000, 6'b100000};

    {RST, MemRead, MemWrite, mem_halt, ihit, dhit} = 6'b100000;
    repeat (2) @(negedge CLK);

    for (int k = 0; k < 29; k++) begin
      drive(tbl[k].in);
      chk($sformatf("vec%0d", k), tbl[k].out);
    end

    // long data access with no dhit
    drive(6'b010010);
    chk("to_issue", 6'b100000);
    begin
      int bad;
      bad = 0;
      for (int c = 0; c < 256; c++) begin
        drive(6'b000000);
        if ({iREN, dREN, pc_en, halt} !== 4'b0100) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL to_wait: %0d bad cycles, want 0", bad);
      end
    end
    drive(6'b000000);
`ifdef REQ_UNIT_TIMEOUT_EN
    chk("to_expire", 6'b000011);
    drive(6'b000011);
    chk("to_sticky", 6'b000011);
`else
    chk("to_nowait", 6'b010000);
    drive(6'b000001);
    chk("to_late_dhit", 6'b010100);
`endif
    drive(6'b100000);
    drive(6'b000000);
    chk("to_reset", 6'b100000);

    // dhit exactly at the last counter value
    drive(6'b010010);
    for (int c = 0; c < 255; c++) drive(6'b000000);
    chk("edge_wait", 6'b010000);
    drive(6'b000001);
    chk("edge_dhit", 6'b010100);
    drive(6'b000000);
    chk("edge_after", 6'b100000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, want finish");
    $fatal(1);
  end

endmodule
